uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Byte-level command responder between the UART receiver and the UART transmitter.
- Parses host command frames (register write or register read) from received bytes and drives a simple register bus.
- Returns exactly one reply byte per frame through the transmitter start/busy handshake.
- Lets a host PC poke and peek pinout-probe registers over RS-232.

Parameters:
- ACK_BYTE, 8'h4B, reply byte for a successful write.
- NAK_BYTE, 8'h3F, reply byte for an unknown command.
- ERR_BYTE, 8'h21, reply byte for a checksum mismatch (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data_ready  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- rx_endofpacket  in  1  one-cycle strobe, receive line went idle
- tx_busy  in  1  transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, valid while tx_start is high
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_re
- overrun  out  1  sticky flag: a byte arrived while the responder was busy

Behaviour:
- Single clock; asynchronous active-low reset (rst_n).
- Reset values: all outputs 0; state IDLE; internal command, address, data and checksum registers 0.
- Frame formats:
  - Write: 0x57 ('W'), A, D.
  - Read: 0x52 ('R'), A.
- States and transitions:
  - IDLE: on rx_data_ready:
    - 0x57 or 0x52: store as command, go to GET_ADDR.
    - Any other byte: load NAK_BYTE, go to SEND.
  - GET_ADDR: on rx_data_ready, latch reg_addr.
    - Command W: go to GET_DATA.
    - Command R: go to READ.
  - GET_DATA: on rx_data_ready, latch reg_wdata, go to WRITE.
  - WRITE: reg_we=1 for exactly one cycle; load ACK_BYTE; go to SEND.
  - READ: reg_re=1 for exactly one cycle; go to READ_CAP.
  - READ_CAP: capture reg_rdata as the reply byte; go to SEND.
  - SEND: when tx_busy==0, assert tx_start for one cycle with tx_data = reply; go to SEND_WAIT. While tx_busy==1, hold in SEND.
  - SEND_WAIT: skip the first cycle unconditionally (the transmitter raises busy one cycle after start). Then wait for tx_busy==0 and go to IDLE.
- Latency:
  - Write frame: last byte strobe to reg_we is 1 cycle; to tx_start is 2 cycles when the transmitter is idle.
  - Read frame: address strobe to reg_re is 1 cycle; to tx_start is 3 cycles.
- Abort: rx_endofpacket in GET_ADDR or GET_DATA returns to IDLE. No bus strobe, no reply. In all other states it is ignored.
- Simultaneous rx_data_ready and rx_endofpacket in the same cycle: the byte wins; the abort is ignored.
- Overrun: rx_data_ready in WRITE, READ, READ_CAP, SEND or SEND_WAIT drops the byte and sets overrun=1. overrun clears only on reset.
- reg_addr and reg_wdata hold their last values between frames.
- Reset mid-frame or mid-send: immediate return to IDLE with tx_start=0. A byte already started in the transmitter finishes on its own.

Optional Feature:
- Macro: UART_CMD_CHKSUM_EN.
- Defined:
  - Every frame carries one trailing checksum byte, the XOR of all preceding frame bytes.
  - Added state GET_CHK follows GET_DATA (write) or GET_ADDR (read).
  - Match: proceed to WRITE or READ.
  - Mismatch: no bus strobe; reply ERR_BYTE.
  - rx_endofpacket in GET_CHK aborts the frame.
- Undefined: no checksum byte is expected; GET_CHK and ERR_BYTE logic are absent.

Test Plan:
- Write: bytes 0x57,0x12,0xA5 with transmitter idle -> one reg_we pulse with reg_addr=0x12, reg_wdata=0xA5; one tx_start with tx_data=0x4B.
- Read: bytes 0x52,0x34 with reg_rdata=0x5C after reg_re -> reg_re pulse with reg_addr=0x34; tx_start 2 cycles later with tx_data=0x5C.
- Unknown command: byte 0x00 -> tx_data=0x3F; no reg_we, no reg_re.
- Abort: 0x57,0x12 then rx_endofpacket -> no reg_we, no tx_start; a following 0x52,0x01 frame completes normally.
- Busy and overrun: tx_busy held 1 during a write reply, and a byte injected in SEND -> tx_start delayed until tx_busy falls; overrun=1; the injected byte is not parsed.
- Checksum (macro defined): 0x57,0x12,0xA5,0xE0 -> write plus ACK. 0x57,0x12,0xA5,0x00 -> no write, tx_data=0x21.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// Byte-level W/R command responder between UART rx/tx and a register bus.
// Build with UART_CMD_CHKSUM_EN to require a trailing XOR checksum byte.
module uart_cmd_responder #(
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F
`ifdef UART_CMD_CHKSUM_EN
  , parameter logic [7:0] ERR_BYTE = 8'h21
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_endofpacket,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       overrun
);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_CMD_CHKSUM_EN
    GET_CHK,
`endif
    WRITE,
    READ,
    READ_CAP,
    SEND,
    SEND_WAIT
  } state_t;

  state_t state, nextState;

  logic       isWrite;
  logic [7:0] reply;
  logic       waitFirst;
  logic       isCmd;
  logic       busyState;

  assign isCmd = (rx_data == 8'h57) || (rx_data == 8'h52);
  assign busyState = (state == WRITE) || (state == READ) ||
                     (state == READ_CAP) || (state == SEND) ||
                     (state == SEND_WAIT);
  assign tx_data = reply;

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] chk;
  logic       chkOk;
  assign chkOk = (rx_data == chk);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    tx_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_data_ready) nextState = isCmd ? GET_ADDR : SEND;
      end
      GET_ADDR: begin
        if (rx_data_ready) begin
`ifdef UART_CMD_CHKSUM_EN
          nextState = isWrite ? GET_DATA : GET_CHK;
`else
          nextState = isWrite ? GET_DATA : READ;
`endif
        end else if (rx_endofpacket) nextState = IDLE;
      end
      GET_DATA: begin
`ifdef UART_CMD_CHKSUM_EN
        if (rx_data_ready) nextState = GET_CHK;
`else
        if (rx_data_ready) nextState = WRITE;
`endif
        else if (rx_endofpacket) nextState = IDLE;
      end
`ifdef UART_CMD_CHKSUM_EN
      GET_CHK: begin
        if (rx_data_ready) begin
          if (!chkOk)       nextState = SEND;
          else if (isWrite) nextState = WRITE;
          else              nextState = READ;
        end else if (rx_endofpacket) nextState = IDLE;
      end
`endif
      WRITE: begin
        reg_we    = 1'b1;
        nextState = SEND;
      end
      READ: begin
        reg_re    = 1'b1;
        nextState = READ_CAP;
      end
      READ_CAP: nextState = SEND;
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          nextState = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        // tx_busy lags tx_start by a cycle, so the first cycle is ignored
        if (!waitFirst && !tx_busy) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isWrite   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reply     <= 8'h00;
      waitFirst <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      waitFirst <= (state == SEND) && !tx_busy;
      if (rx_data_ready && busyState) overrun <= 1'b1;
      if (state == IDLE && rx_data_ready) begin
        if (isCmd) isWrite <= (rx_data == 8'h57);
        else       reply   <= NAK_BYTE;
`ifdef UART_CMD_CHKSUM_EN
        chk <= rx_data;
`endif
      end
      if (state == GET_ADDR && rx_data_ready) begin
        reg_addr <= rx_data;
`ifdef UART_CMD_CHKSUM_EN
        chk <= chk ^ rx_data;
`endif
      end
      if (state == GET_DATA && rx_data_ready) begin
        reg_wdata <= rx_data;
`ifdef UART_CMD_CHKSUM_EN
        chk <= chk ^ rx_data;
`endif
      end
`ifdef UART_CMD_CHKSUM_EN
      if (state == GET_CHK && rx_data_ready && !chkOk) reply <= ERR_BYTE;
`endif
      if (state == WRITE)    reply <= ACK_BYTE;
      if (state == READ_CAP) reply <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder.
// Define UART_CMD_CHKSUM_EN to exercise the checksum build.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_endofpacket;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       overrun;

  int nAsserts = 0;
  int nFail = 0;
  int weCount = 0;
  int reCount = 0;
  int startCount = 0;

  uart_cmd_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data_ready(rx_data_ready),
    .rx_data(rx_data),
    .rx_endofpacket(rx_endofpacket),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we)   weCount++;
    if (reg_re)   reCount++;
    if (tx_start) startCount++;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    rx_endofpacket = 1'b0;
    tx_busy = 1'b0;
    reg_rdata = 8'h5C;
    tick(2);
    chk("rst tx_start", {7'd0, tx_start}, 8'h00);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst reg_addr", reg_addr, 8'h00);
    chk("rst reg_wdata", reg_wdata, 8'h00);
    chk("rst strobes", {6'd0, reg_we, reg_re}, 8'h00);
    chk("rst overrun", {7'd0, overrun}, 8'h00);
    rst_n = 1'b1;
    tick();

    // write 0x57 0x12 0xA5
    sendByte(8'h57);
    sendByte(8'h12);
    sendByte(8'hA5);
`ifdef UART_CMD_CHKSUM_EN
    sendByte(8'hE0);
`endif
    chk("wr reg_we", {7'd0, reg_we}, 8'h01);
    chk("wr reg_addr", reg_addr, 8'h12);
    chk("wr reg_wdata", reg_wdata, 8'hA5);
    chk("wr early start", {7'd0, tx_start}, 8'h00);
    tick();
    chk("wr we once", {7'd0, reg_we}, 8'h00);
    chk("wr tx_start", {7'd0, tx_start}, 8'h01);
    chk("wr tx_data", tx_data, 8'h4B);
    tick(4);
    chk("wr we count", 8'(weCount), 8'd1);
    chk("wr start count", 8'(startCount), 8'd1);

    // read 0x52 0x34
    sendByte(8'h52);
    sendByte(8'h34);
`ifdef UART_CMD_CHKSUM_EN
    sendByte(8'h66);
`endif
    chk("rd reg_re", {7'd0, reg_re}, 8'h01);
    chk("rd reg_addr", reg_addr, 8'h34);
    tick();
    chk("rd cap no start", {7'd0, tx_start}, 8'h00);
    tick();
    chk("rd tx_start", {7'd0, tx_start}, 8'h01);
    chk("rd tx_data", tx_data, 8'h5C);
    tick(4);
    chk("rd re count", 8'(reCount), 8'd1);

    // unknown command
    sendByte(8'h00);
    chk("nak tx_start", {7'd0, tx_start}, 8'h01);
    chk("nak tx_data", tx_data, 8'h3F);
    tick(4);
    chk("nak we count", 8'(weCount), 8'd1);
    chk("nak re count", 8'(reCount), 8'd1);

    // abort mid-frame, then a clean read
    sendByte(8'h57);
    sendByte(8'h12);
    rx_endofpacket = 1'b1;
    tick();
    rx_endofpacket = 1'b0;
    tick(3);
    chk("abort we count", 8'(weCount), 8'd1);
    chk("abort start count", 8'(startCount), 8'd3);
    reg_rdata = 8'hC3;
    sendByte(8'h52);
    sendByte(8'h01);
`ifdef UART_CMD_CHKSUM_EN
    sendByte(8'h53);
`endif
    chk("post-abort reg_re", {7'd0, reg_re}, 8'h01);
    chk("post-abort addr", reg_addr, 8'h01);
    tick(2);
    chk("post-abort start", {7'd0, tx_start}, 8'h01);
    chk("post-abort data", tx_data, 8'hC3);
    tick(4);

    // byte and eop together: byte wins
    sendByte(8'h57);
    rx_endofpacket = 1'b1;
    sendByte(8'h12);
    rx_endofpacket = 1'b0;
    sendByte(8'hA5);
`ifdef UART_CMD_CHKSUM_EN
    sendByte(8'hE0);
`endif
    chk("eop+byte reg_we", {7'd0, reg_we}, 8'h01);
    tick(5);
    chk("eop+byte we count", 8'(weCount), 8'd2);

    // busy transmitter and overrun
    chk("pre overrun", {7'd0, overrun}, 8'h00);
    tx_busy = 1'b1;
    sendByte(8'h57);
    sendByte(8'h12);
    sendByte(8'hA5);
`ifdef UART_CMD_CHKSUM_EN
    sendByte(8'hE0);
`endif
    tick();
    chk("busy hold start", {7'd0, tx_start}, 8'h00);
    sendByte(8'h52);
    chk("overrun set", {7'd0, overrun}, 8'h01);
    chk("busy still held", {7'd0, tx_start}, 8'h00);
    tick(3);
    tx_busy = 1'b0;
    #1;
    chk("busy release start", {7'd0, tx_start}, 8'h01);
    chk("busy release data", tx_data, 8'h4B);
    tick(4);
    chk("injected not parsed", 8'(reCount), 8'd2);
    sendByte(8'h00);
    chk("idle after overrun", tx_data, 8'h3F);
    chk("overrun sticky", {7'd0, overrun}, 8'h01);
    tick(4);

`ifdef UART_CMD_CHKSUM_EN
    // bad checksum
    sendByte(8'h57);
    sendByte(8'h12);
    sendByte(8'hA5);
    sendByte(8'h00);
    chk("chk bad start", {7'd0, tx_start}, 8'h01);
    chk("chk bad data", tx_data, 8'h21);
    tick(4);
    chk("chk bad no write", 8'(weCount), 8'd3);
`endif

    // reset mid-frame
    sendByte(8'h57);
    sendByte(8'h77);
    rst_n = 1'b0;
    #1;
    chk("midrst addr", reg_addr, 8'h00);
    chk("midrst overrun", {7'd0, overrun}, 8'h00);
    chk("midrst tx_start", {7'd0, tx_start}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    sendByte(8'hFF);
    chk("post-rst nak", tx_data, 8'h3F);
    chk("post-rst start", {7'd0, tx_start}, 8'h01);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
